// File: rtl/bin2bcd_secuencial_pkg.sv
// Shared constants for the multiplier/BCD display path: default widths and
// the converter state encodings.
package bin2bcd_secuencial_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;
    localparam int DEF_CNT_W  = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

endpackage

// File: rtl/bin2bcd_secuencial_if.sv
// Handshake and data bus between the multiplier glue logic and the converter.
interface bin2bcd_secuencial_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );

endinterface

// File: rtl/bin2bcd_secuencial_bcd_ajuste_digito.sv
// One double-dabble digit correction: add 3 to a BCD nibble that is 5 or more
// so the following left shift carries correctly into the next decimal digit.
module bcd_ajuste_digito (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_secuencial.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/busy/done handshake towards the 7-segment display path.
module bin2bcd_secuencial
    import bin2bcd_secuencial_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin2bcd_secuencial_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_shift;
    logic             r_busy;
    logic             r_done;
    logic [BCD_W-1:0] r_bcd;

    logic [SR_W-1:0]  w_adj;
    logic [SR_W-1:0]  w_next;

    // Binary part passes through untouched; only the BCD nibbles are corrected.
    assign w_adj[WIDTH-1:0] = r_shift[WIDTH-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_ajuste_digito u_adj (
            .i_digit (r_shift[WIDTH + 4*g +: 4]),
            .o_digit (w_adj[WIDTH + 4*g +: 4])
        );
    end

    assign w_next = {w_adj[SR_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shift <= {{BCD_W{1'b0}}, bus.bin};
                        r_cnt   <= '0;
                        r_state <= ST_CONV;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CONV: begin
                    r_shift <= w_next;
                    r_cnt   <= r_cnt + 1'b1;
                    // Last bit: publish the result from the final adjust+shift.
                    if (r_cnt == LAST_CNT) begin
                        r_bcd   <= w_next[SR_W-1 -: BCD_W];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;

endmodule
